bcd_scan_counter: RTL and testbench
===================================

// Module: bcd_scan_counter
//
// PURPOSE
//   Multi-digit decimal (BCD) up/down counter with time-multiplexed digit scan.
//   It is the stage directly upstream of the BCD-to-7-segment decoder.
//   Each scan slot presents one 4-bit BCD digit on bcd_out. The decoder takes
//   bcd_out[3] as x1 (MSB) through bcd_out[0] as x4 (LSB).
//   A matching active-low digit enable drives the common-anode display.
//
// PARAMETERS
//   NUM_DIGITS  4     number of BCD digits (1..8); digit 0 = least significant
//   SCAN_DIV    1000  clk cycles each digit stays selected (>=2)
//
// PORTS
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   en         in   1             count enable; one step per cycle while high
//   up         in   1             1 = increment, 0 = decrement
//   load       in   1             synchronous load of load_val; overrides en
//   load_val   in   4*NUM_DIGITS  packed BCD preset; digit i = [4i+3:4i]
//   count      out  4*NUM_DIGITS  current packed BCD count (registered)
//   carry      out  1             1-cycle pulse on wrap (up: max->0, down: 0->max)
//   bcd_out    out  4             BCD digit of the selected scan slot, to decoder
//   digit_sel  out  NUM_DIGITS    one-hot active-low digit enable, aligned with bcd_out
//
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous, takes effect immediately):
//     - count=0, carry=0, bcd_out=0
//     - scan index=0, digit_sel = ~1 (digit 0 active), scan prescaler=0
//   Count register (per clk edge, priority load > en):
//     - load=1: count <= load_val; any nibble >9 is stored as 0; carry=0.
//     - en=1, up=1: decimal increment with ripple. A digit at 9 becomes 0 and
//       carries into the next digit. All-9s -> all-0s with carry=1 that cycle.
//     - en=1, up=0: decimal decrement with borrow. A digit at 0 becomes 9 and
//       borrows from the next digit. All-0s -> all-9s with carry=1 that cycle.
//     - en=0: hold; carry=0.
//     - carry is registered and high for exactly the one cycle after the
//       wrapping edge.
//   Scan:
//     - Prescaler counts 0..SCAN_DIV-1 and wraps.
//     - On the cycle the prescaler is at SCAN_DIV-1, the scan index advances:
//       0,1,...,NUM_DIGITS-1,0.
//     - digit_sel and bcd_out are registered together; both change on the
//       same edge.
//     - bcd_out = digit[index] of count as sampled on that edge (1-cycle
//       latency from count).
//     - bcd_out tracks the selected digit every cycle, not only at slot change.
//     - digit_sel always has exactly one bit low. It is never all-high or
//       multi-low, including across reset release.
//   Boundary conditions:
//     - load and en both high: load wins, no count step, carry=0.
//     - load of an all-9s value with en=1, up=1: the value loads; it wraps on
//       the next cycle only.
//     - NUM_DIGITS=1: index stays 0; digit_sel = 1'b0 permanently.
//     - Reset mid-scan: prescaler and index restart at 0.
//     - bcd_out is never >9 in any state.
//
// TESTING (bench uses NUM_DIGITS=4, SCAN_DIV=4)
//   1 Reset: assert rst_n=0 mid-cycle -> count=0000, bcd_out=0,
//     digit_sel=4'b1110, carry=0 without a clock edge.
//   2 Up wrap: load 16'h9998, then en=1 up=1 for 2 cycles -> 9999, then 0000
//     with carry=1 for one cycle only.
//   3 Down wrap/borrow: load 16'h1000, en=1 up=0 -> 0999; load 0000, one
//     step -> 9999 with carry=1.
//   4 Load sanitise/priority: load=1 en=1 load_val=16'h3A7F -> count=16'h3070,
//     no step, carry=0.
//   5 Scan: count=16'h4321 held -> bcd_out/digit_sel sequence
//     1/1110, 2/1101, 3/1011, 4/0111, 1/1110.
//     Each pair lasts 4 cycles; always exactly one bit of digit_sel is low.
//   6 Live update: en=1 up=1 during scan from 0000 ->
//     bcd_out equals count[3:0] delayed one cycle while digit 0 is selected.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with time-multiplexed, active-low digit scan
// feeding a BCD-to-7-segment decoder.
module bcd_scan_counter #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    carry,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int unsigned CW = 4 * NUM_DIGITS;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = $clog2(SCAN_DIV);

    logic [CW-1:0] count_nxt;
    logic          carry_nxt;
    logic          ripple;
    logic [3:0]    dig;
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic          slot_end;
    logic [3:0]    sel_digit;

    // Next count: load (with nibble sanitising) beats a ripple step
    always_comb begin
        count_nxt = count;
        carry_nxt = 1'b0;
        ripple    = 1'b0;
        dig       = '0;
        if (load) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                dig = load_val[4*i +: 4];
                count_nxt[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
            end
        end else if (en) begin
            ripple = 1'b1;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                dig = count[4*i +: 4];
                if (ripple) begin
                    if (up) begin
                        if (dig == 4'd9) begin
                            dig = 4'd0;
                        end else begin
                            dig    = dig + 4'd1;
                            ripple = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            dig = 4'd9;
                        end else begin
                            dig    = dig - 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
                count_nxt[4*i +: 4] = dig;
            end
            carry_nxt = ripple;
        end
    end

    // Scan slot advance and digit pick for the slot selected after this edge
    always_comb begin
        slot_end = (presc == PW'(SCAN_DIV - 1));
        idx_nxt  = idx;
        if (slot_end) begin
            idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end
        sel_digit = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IW'(i) == idx_nxt) begin
                sel_digit = count[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
        end else begin
            count <= count_nxt;
            carry <= carry_nxt;
        end
    end

    // digit_sel and bcd_out share one register stage so they never skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= '0;
            digit_sel <= ~NUM_DIGITS'(1);
            bcd_out   <= '0;
        end else begin
            presc     <= slot_end ? '0 : presc + PW'(1);
            idx       <= idx_nxt;
            digit_sel <= ~(NUM_DIGITS'(1) << idx_nxt);
            bcd_out   <= sel_digit;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter: directed scenarios plus random
// stimulus against an integer-valued reference model.
module tb_bcd_scan_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: decimal value, carry, scan outputs, edges since reset
    int         m_val;
    logic       m_carry;
    logic [3:0] m_bcd;
    logic [3:0] m_sel;
    int         m_cyc;

    bcd_scan_counter #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .carry(carry),
        .bcd_out(bcd_out), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int sanitize(input logic [15:0] lv);
        int r;
        int m;
        logic [3:0] nib;
        r = 0;
        m = 1;
        for (int i = 0; i < 4; i++) begin
            nib = lv[4*i +: 4];
            if (nib <= 4'd9) r += int'(nib) * m;
            m *= 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_of(input int v, input int d);
        for (int i = 0; i < d; i++) v = v / 10;
        return 4'(v % 10);
    endfunction

    task automatic model_reset();
        m_val = 0; m_carry = 1'b0; m_bcd = 4'd0; m_sel = 4'b1110; m_cyc = 0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle
    task automatic tick(input logic t_en, input logic t_up, input logic t_load,
                        input logic [15:0] t_lv);
        int n;
        int slot;
        en = t_en; up = t_up; load = t_load; load_val = t_lv;
        @(posedge clk);
        n     = m_cyc + 1;
        slot  = (n / 4) % 4;
        m_bcd = digit_of(m_val, slot);
        m_sel = ~(4'b0001 << slot);
        if (t_load) begin
            m_val = sanitize(t_lv); m_carry = 1'b0;
        end else if (t_en && t_up) begin
            m_carry = (m_val == 9999); m_val = (m_val + 1) % 10000;
        end else if (t_en) begin
            m_carry = (m_val == 0); m_val = (m_val + 9999) % 10000;
        end else begin
            m_carry = 1'b0;
        end
        m_cyc = n;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 1'b0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks += 4;
        if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got=%h exp=0000", count); end
        if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b exp=0", carry); end
        if (bcd_out !== 4'd0) begin n_fail++; $display("FAIL reset_bcd got=%h exp=0", bcd_out); end
        if (digit_sel !== 4'b1110) begin n_fail++; $display("FAIL reset_sel got=%b exp=1110", digit_sel); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_up_wrap();
        logic [15:0] exp_c [3];
        logic        exp_k [3];
        exp_c = '{16'h9999, 16'h0000, 16'h0000};
        exp_k = '{1'b0, 1'b1, 1'b0};
        tick(1'b0, 1'b1, 1'b1, 16'h9998);
        n_checks++;
        if (count !== 16'h9998) begin n_fail++; $display("FAIL upwrap_load got=%h exp=9998", count); end
        for (int i = 0; i < 3; i++) begin
            tick(i < 2, 1'b1, 1'b0, 16'h0);
            n_checks += 2;
            if (count !== exp_c[i]) begin n_fail++; $display("FAIL upwrap_count step=%0d got=%h exp=%h", i, count, exp_c[i]); end
            if (carry !== exp_k[i]) begin n_fail++; $display("FAIL upwrap_carry step=%0d got=%b exp=%b", i, carry, exp_k[i]); end
        end
    endtask

    task automatic test_down_wrap();
        tick(1'b0, 1'b0, 1'b1, 16'h1000);
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        n_checks += 2;
        if (count !== 16'h0999) begin n_fail++; $display("FAIL borrow_count got=%h exp=0999", count); end
        if (carry !== 1'b0) begin n_fail++; $display("FAIL borrow_carry got=%b exp=0", carry); end
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        n_checks += 2;
        if (count !== 16'h9999) begin n_fail++; $display("FAIL downwrap_count got=%h exp=9999", count); end
        if (carry !== 1'b1) begin n_fail++; $display("FAIL downwrap_carry got=%b exp=1", carry); end
        tick(1'b0, 1'b0, 1'b0, 16'h0);
        n_checks++;
        if (carry !== 1'b0) begin n_fail++; $display("FAIL downwrap_carry_pulse got=%b exp=0", carry); end
    endtask

    task automatic test_load_priority();
        tick(1'b1, 1'b1, 1'b1, 16'h3A7F);
        n_checks += 2;
        if (count !== 16'h3070) begin n_fail++; $display("FAIL loadprio_count got=%h exp=3070", count); end
        if (carry !== 1'b0) begin n_fail++; $display("FAIL loadprio_carry got=%b exp=0", carry); end
        tick(1'b1, 1'b1, 1'b1, 16'h9999);
        tick(1'b1, 1'b1, 1'b0, 16'h0);
        n_checks += 2;
        if (count !== 16'h0000) begin n_fail++; $display("FAIL load9999_next got=%h exp=0000", count); end
        if (carry !== 1'b1) begin n_fail++; $display("FAIL load9999_carry got=%b exp=1", carry); end
    endtask

    // Fresh reset so the slot phase is known, then compare against fixed pattern
    task automatic test_scan();
        logic [3:0] exp_d;
        logic [3:0] exp_s;
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 16'h4321);
        for (int n = 2; n < 22; n++) begin
            tick(1'b0, 1'b0, 1'b0, 16'h0);
            exp_d = 4'(((n / 4) % 4) + 1);
            exp_s = ~(4'b0001 << ((n / 4) % 4));
            n_checks += 3;
            if (bcd_out !== exp_d) begin n_fail++; $display("FAIL scan_bcd n=%0d got=%h exp=%h", n, bcd_out, exp_d); end
            if (digit_sel !== exp_s) begin n_fail++; $display("FAIL scan_sel n=%0d got=%b exp=%b", n, digit_sel, exp_s); end
            if ($countones(~digit_sel) != 1) begin n_fail++; $display("FAIL scan_onehot n=%0d got=%b exp=one low", n, digit_sel); end
        end
    endtask

    task automatic test_live_update();
        logic [3:0] prev_d0;
        int         seen;
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        prev_d0 = count[3:0];
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, 1'b1, 1'b0, 16'h0);
            if (digit_sel === 4'b1110) begin
                seen++;
                n_checks++;
                if (bcd_out !== prev_d0) begin n_fail++; $display("FAIL live_bcd i=%0d got=%h exp=%h", i, bcd_out, prev_d0); end
            end
            prev_d0 = count[3:0];
        end
        n_checks++;
        if (seen < 4) begin n_fail++; $display("FAIL live_slots got=%0d exp>=4", seen); end
    endtask

    task automatic test_random();
        logic [15:0] lv;
        for (int i = 0; i < 400; i++) begin
            lv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lv = (lv & 16'h0101) | 16'h9898;
            tick(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), lv);
            n_checks += 5;
            if (count !== to_bcd(m_val)) begin n_fail++; $display("FAIL rnd_count i=%0d got=%h exp=%h", i, count, to_bcd(m_val)); end
            if (carry !== m_carry) begin n_fail++; $display("FAIL rnd_carry i=%0d got=%b exp=%b", i, carry, m_carry); end
            if (bcd_out !== m_bcd) begin n_fail++; $display("FAIL rnd_bcd i=%0d got=%h exp=%h", i, bcd_out, m_bcd); end
            if (digit_sel !== m_sel) begin n_fail++; $display("FAIL rnd_sel i=%0d got=%b exp=%b", i, digit_sel, m_sel); end
            if (bcd_out > 4'd9) begin n_fail++; $display("FAIL rnd_bcd_range i=%0d got=%h exp<=9", i, bcd_out); end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_scan();
        test_live_update();
        test_random();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
